// File: rtl/tpu_sched_pkg.sv
// Shared definitions for the matrix-unit job scheduler: FSM states,
// job geometry, flag bit positions and the default RUN timeout.
package tpu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    localparam int OPERAND_BYTES   = 8;
    localparam int RESULT_BYTES    = 8;

    // Bit positions inside the 3-bit {elemwise, activation, transpose} flag field
    localparam int FLAG_TRANSPOSE  = 0;
    localparam int FLAG_ACTIVATION = 1;
    localparam int FLAG_ELEMWISE   = 2;
    localparam int FLAG_W          = 3;

    localparam int TIMEOUT_DEFAULT = 64;

    // Byte k of the 64-bit result buffer {c00, c01, c10, c11}, most significant byte first
    function automatic logic [7:0] result_byte(input logic [63:0] buf_in, input logic [2:0] k);
        return buf_in[8*(7 - int'(k)) +: 8];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win
// last time is chosen; the last-grant pointer only moves when advance is set.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_id,
    output logic       grant_any
);

    logic last_grant_reg;

    // Pick the winner from the current requests and the last-grant pointer
    always_comb begin
        grant_any = |req;
        if (req == 2'b11) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = req[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (advance && grant_any) begin
            last_grant_reg <= grant_id;
        end
    end

endmodule

// File: rtl/mmu_job_scheduler.sv
// Shares one 2x2 systolic matrix unit between two requesters: arbitrates,
// streams 8 operand bytes into the operand memory, starts the array, waits
// for results (with timeout) and returns them as 8 tagged response bytes.
module mmu_job_scheduler
    import tpu_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    input  logic [2:0]  req_flags0,
    input  logic [2:0]  req_flags1,
    output logic        mem_load_en,
    output logic [2:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        mmu_clear,
    output logic        mmu_start,
    output logic        mmu_transpose,
    output logic        mmu_activation,
    output logic        mmu_elemwise,
    input  logic        mmu_done,
    input  logic [15:0] c00,
    input  logic [15:0] c01,
    input  logic [15:0] c10,
    input  logic [15:0] c11,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_data,
    output logic        resp_id,
    output logic        resp_last,
    output logic        resp_err,
    output logic        busy
);

    localparam int               CNT_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_BYTE_IN  = 3'(OPERAND_BYTES - 1);
    localparam logic [2:0]       LAST_BYTE_OUT = 3'(RESULT_BYTES - 1);

    sched_state_e      state_reg, state_next;
    logic              gid_reg, gid_next;
    logic [2:0]        byte_cnt_reg, byte_cnt_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [63:0]       result_reg, result_next;
    logic [FLAG_W-1:0] flags_reg, flags_next;

    logic [1:0]        req_ready_reg, req_ready_next;
    logic              mem_load_en_reg, mem_load_en_next;
    logic [2:0]        mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_data_reg, mem_data_next;
    logic              mmu_clear_reg, mmu_clear_next;
    logic              mmu_start_reg, mmu_start_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [7:0]        resp_data_reg, resp_data_next;
    logic              resp_id_reg, resp_id_next;
    logic              resp_last_reg, resp_last_next;
    logic              resp_err_reg, resp_err_next;
    logic              busy_reg, busy_next;

    logic              arb_id, arb_any, arb_advance;
    logic [1:0]        req_fire;
    logic              load_fire;
    logic [7:0]        load_data;
    logic [FLAG_W-1:0] load_flags;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (arb_advance),
        .grant_id  (arb_id),
        .grant_any (arb_any)
    );

    // A byte transfers only where valid meets the (registered) ready
    for (genvar gi = 0; gi < 2; gi++) begin : g_fire
        assign req_fire[gi] = req_valid[gi] & req_ready_reg[gi];
    end

    assign load_fire  = |req_fire;
    assign load_data  = gid_reg ? req_data1 : req_data0;
    assign load_flags = gid_reg ? req_flags1 : req_flags0;

    // Next-state and next-output logic for the job sequencer
    always_comb begin
        state_next       = state_reg;
        gid_next         = gid_reg;
        byte_cnt_next    = byte_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        result_next      = result_reg;
        flags_next       = flags_reg;
        req_ready_next   = 2'b00;
        mem_load_en_next = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_data_next    = mem_data_reg;
        mmu_clear_next   = 1'b0;
        mmu_start_next   = 1'b0;
        resp_valid_next  = resp_valid_reg;
        resp_data_next   = resp_data_reg;
        resp_id_next     = resp_id_reg;
        resp_last_next   = resp_last_reg;
        resp_err_next    = resp_err_reg;
        arb_advance      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_advance    = 1'b1;
                    gid_next       = arb_id;
                    mmu_clear_next = 1'b1;
                    byte_cnt_next  = '0;
                    req_ready_next = arb_id ? 2'b10 : 2'b01;
                    state_next     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                req_ready_next = req_ready_reg;
                if (load_fire) begin
                    mem_load_en_next = 1'b1;
                    mem_addr_next    = byte_cnt_reg;
                    mem_data_next    = load_data;
                    if (byte_cnt_reg == '0) begin
                        flags_next = load_flags;
                    end
                    byte_cnt_next = byte_cnt_reg + 3'd1;
                    if (byte_cnt_reg == LAST_BYTE_IN) begin
                        req_ready_next = 2'b00;
                        wait_cnt_next  = '0;
                        state_next     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Counter is zero only in the first RUN cycle, giving a one-cycle start
                mmu_start_next = (wait_cnt_reg == '0);
                wait_cnt_next  = wait_cnt_reg + 1'b1;
                if (mmu_done || (wait_cnt_reg == WAIT_LAST)) begin
                    // Done takes priority over an expiring timeout in the same cycle
                    result_next     = mmu_done ? {c00, c01, c10, c11} : 64'd0;
                    resp_err_next   = ~mmu_done;
                    resp_valid_next = 1'b1;
                    resp_data_next  = result_byte(result_next, 3'd0);
                    resp_id_next    = gid_reg;
                    resp_last_next  = 1'b0;
                    byte_cnt_next   = '0;
                    state_next      = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (resp_ready) begin
                    if (byte_cnt_reg == LAST_BYTE_OUT) begin
                        resp_valid_next = 1'b0;
                        resp_last_next  = 1'b0;
                        state_next      = ST_IDLE;
                    end else begin
                        byte_cnt_next  = byte_cnt_reg + 3'd1;
                        resp_data_next = result_byte(result_reg, byte_cnt_reg + 3'd1);
                        resp_last_next = ((byte_cnt_reg + 3'd1) == LAST_BYTE_OUT);
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Job context, counters, result buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid_reg         <= 1'b0;
            byte_cnt_reg    <= '0;
            wait_cnt_reg    <= '0;
            result_reg      <= '0;
            flags_reg       <= '0;
            req_ready_reg   <= '0;
            mem_load_en_reg <= 1'b0;
            mem_addr_reg    <= '0;
            mem_data_reg    <= '0;
            mmu_clear_reg   <= 1'b0;
            mmu_start_reg   <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= '0;
            resp_id_reg     <= 1'b0;
            resp_last_reg   <= 1'b0;
            resp_err_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            gid_reg         <= gid_next;
            byte_cnt_reg    <= byte_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            result_reg      <= result_next;
            flags_reg       <= flags_next;
            req_ready_reg   <= req_ready_next;
            mem_load_en_reg <= mem_load_en_next;
            mem_addr_reg    <= mem_addr_next;
            mem_data_reg    <= mem_data_next;
            mmu_clear_reg   <= mmu_clear_next;
            mmu_start_reg   <= mmu_start_next;
            resp_valid_reg  <= resp_valid_next;
            resp_data_reg   <= resp_data_next;
            resp_id_reg     <= resp_id_next;
            resp_last_reg   <= resp_last_next;
            resp_err_reg    <= resp_err_next;
            busy_reg        <= busy_next;
        end
    end

    assign req_ready      = req_ready_reg;
    assign mem_load_en    = mem_load_en_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_data       = mem_data_reg;
    assign mmu_clear      = mmu_clear_reg;
    assign mmu_start      = mmu_start_reg;
    assign mmu_transpose  = flags_reg[FLAG_TRANSPOSE];
    assign mmu_activation = flags_reg[FLAG_ACTIVATION];
    assign mmu_elemwise   = flags_reg[FLAG_ELEMWISE];
    assign resp_valid     = resp_valid_reg;
    assign resp_data      = resp_data_reg;
    assign resp_id        = resp_id_reg;
    assign resp_last      = resp_last_reg;
    assign resp_err       = resp_err_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_mmu_job_scheduler.sv
// Self-checking bench for mmu_job_scheduler: directed job sequences with
// randomized data, stalls and array latency, checked against a job-level model.
module tb_mmu_job_scheduler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_data0, req_data1;
    logic [2:0]  req_flags0, req_flags1;
    logic        mem_load_en;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mmu_clear, mmu_start;
    logic        mmu_transpose, mmu_activation, mmu_elemwise;
    logic        mmu_done;
    logic [15:0] c00, c01, c10, c11;
    logic        resp_valid, resp_ready;
    logic [7:0]  resp_data;
    logic        resp_id, resp_last, resp_err, busy;

    mmu_job_scheduler #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .req_flags0     (req_flags0),
        .req_flags1     (req_flags1),
        .mem_load_en    (mem_load_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mmu_clear      (mmu_clear),
        .mmu_start      (mmu_start),
        .mmu_transpose  (mmu_transpose),
        .mmu_activation (mmu_activation),
        .mmu_elemwise   (mmu_elemwise),
        .mmu_done       (mmu_done),
        .c00            (c00),
        .c01            (c01),
        .c10            (c10),
        .c11            (c11),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .resp_last      (resp_last),
        .resp_err       (resp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          pending [2];
    logic [63:0] job_bytes [2];
    logic [2:0]  job_flags [2];
    logic [63:0] job_c;
    int          last_w = 1;   // model pointer: requester 0 wins the first tie

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
        logic [63:0] t;
        t = v >> (8 * (7 - (k & 7)));
        return t[7:0];
    endfunction

    function automatic logic [31:0] all_outputs();
        return {req_ready, mem_load_en, mem_addr, mem_data, mmu_clear, mmu_start,
                mmu_transpose, mmu_activation, mmu_elemwise, resp_valid, resp_data,
                resp_id, resp_last, resp_err, busy};
    endfunction

    task automatic drive_req(input int w, input int acc);
        req_data0  = byte_of(job_bytes[0], (w == 0 && acc < 8) ? acc : 0);
        req_data1  = byte_of(job_bytes[1], (w == 1 && acc < 8) ? acc : 0);
        req_flags0 = job_flags[0];
        req_flags1 = job_flags[1];
    endtask

    task automatic submit(input int r, input logic [63:0] bytes, input logic [2:0] flags);
        pending[r]   = 1'b1;
        job_bytes[r] = bytes;
        job_flags[r] = flags;
        req_valid[r] = 1'b1;
        drive_req(-1, 0);
    endtask

    task automatic submit_rand(input int r);
        submit(r, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
    endtask

    // One arbitration + job. done_mode: 0 normal latency, 1 withheld, 2 at expiry cycle.
    task automatic do_job(input int stall_pct, input int hold_k, input int done_mode, input int abort_at);
        int w, acc, wr, starts, clears, k, last_acc, done_cyc, hold_left;
        bit saw_ready, saw_resp, finished, aborted, v;
        bit exp_err;
        logic [63:0] exp_resp;

        if (pending[0] && pending[1]) w = 1 - last_w;
        else if (pending[1])          w = 1;
        else                          w = 0;
        last_w   = w;
        exp_err  = (done_mode == 1);
        exp_resp = exp_err ? 64'd0 : job_c;
        {c00, c01, c10, c11} = job_c;
        acc = 0; wr = 0; starts = 0; clears = 0; k = 0;
        last_acc = -100; done_cyc = -1; hold_left = 5;
        saw_ready = 0; saw_resp = 0; finished = 0; aborted = 0;

        for (int n = 0; n < 400 && !finished && !aborted; n++) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && acc == abort_at) begin
                rst_n = 1'b0;
                #2;
                check("async_reset_outputs", all_outputs(), 32'd0);
                aborted = 1;
            end else begin
                // observe cycle outputs
                if (req_ready != 2'b00) begin
                    check("grant_owner", req_ready, (w == 0) ? 2'b01 : 2'b10);
                    check("ready_only_in_load", acc < 8, 1);
                    if (!saw_ready) begin
                        check("clear_with_grant", mmu_clear, 1);
                        saw_ready = 1;
                    end
                end
                if (mmu_clear) clears++;
                if (mem_load_en) begin
                    check("mem_addr", mem_addr, wr & 7);
                    check("mem_data", mem_data, byte_of(job_bytes[w], wr));
                    if (wr == 0)
                        check("flags", {mmu_elemwise, mmu_activation, mmu_transpose}, job_flags[w]);
                    wr++;
                end
                if (mmu_start) begin
                    starts++;
                    check("start_latency", cyc, last_acc + 2);
                    if (done_mode == 0)      done_cyc = cyc + $urandom_range(0, 4);
                    else if (done_mode == 2) done_cyc = last_acc + TO;
                end
                if (resp_valid) begin
                    if (!saw_resp) begin
                        saw_resp = 1;
                        if (exp_err) check("timeout_latency", cyc, last_acc + TO + 1);
                        else         check("done_latency", cyc, done_cyc + 1);
                    end
                    check("resp_data", resp_data, byte_of(exp_resp, k));
                    check("resp_id", resp_id, w);
                    check("resp_last", resp_last, k == 7);
                    check("resp_err", resp_err, exp_err);
                end
                // drive inputs for this cycle
                mmu_done = (cyc == done_cyc);
                for (int r = 0; r < 2; r++) begin
                    v = pending[r];
                    if (r == w && saw_ready && stall_pct > 0 && $urandom_range(0, 99) < stall_pct)
                        v = 0;
                    req_valid[r] = v;
                end
                drive_req(w, acc);
                if (resp_valid && k == hold_k && hold_left > 0) begin
                    resp_ready = 1'b0;
                    hold_left--;
                end else begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                // transfers that complete at the coming edge
                if (req_valid[w] && req_ready[w]) begin
                    acc++;
                    if (acc == 8) begin
                        last_acc   = cyc;
                        pending[w] = 1'b0;
                    end
                end
                if (resp_valid && resp_ready) begin
                    k++;
                    if (k == 8) finished = 1;
                end
            end
        end

        if (!aborted) begin
            check("job_completed", finished, 1);
            mmu_done = 1'b0;
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_resp_valid", resp_valid, 0);
            check("start_pulses", starts, 1);
            check("clear_pulses", clears, 1);
            check("mem_writes", wr, 8);
            $display("job: winner=%0d err=%0d stall=%0d hold=%0d mode=%0d", w, exp_err, stall_pct, hold_k, done_mode);
        end else begin
            $display("job: winner=%0d aborted by reset after %0d bytes", w, acc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
        req_flags0 = '0; req_flags1 = '0; mmu_done = 1'b0; resp_ready = 1'b0;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        pending[0] = 0; pending[1] = 0;
        job_bytes[0] = '0; job_bytes[1] = '0; job_flags[0] = '0; job_flags[1] = '0;
        job_c = '0;
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Both requesters valid from reset: grants alternate 0,1,0,1
        submit_rand(0); submit_rand(1);
        job_c = {$urandom, $urandom}; do_job(20, -1, 0, -1);
        submit_rand(0);
        job_c = {$urandom, $urandom}; do_job(20, -1, 0, -1);
        submit_rand(1);
        job_c = {$urandom, $urandom}; do_job(20, -1, 0, -1);
        submit_rand(0);
        job_c = {$urandom, $urandom}; do_job(20, -1, 0, -1);
        job_c = {$urandom, $urandom}; do_job(0, -1, 0, -1);

        // Requester 0 alone with a known operand and result pattern
        submit(0, 64'h0102030405060708, 3'b000);
        job_c = {16'h1234, 16'h5678, 16'h9abc, 16'hdef0};
        do_job(0, -1, 0, -1);

        // Response back-pressure at byte 3
        submit_rand(1);
        job_c = {$urandom, $urandom}; do_job(0, 3, 0, -1);

        // Array never answers: timeout
        submit_rand(0);
        job_c = {$urandom, $urandom}; do_job(0, -1, 1, -1);

        // Done arrives exactly in the expiry cycle
        submit_rand(1);
        job_c = {$urandom, $urandom}; do_job(0, -1, 2, -1);

        // mmu_done while idle is ignored
        mmu_done = 1'b1;
        @(posedge clk); #1;
        mmu_done = 1'b0;
        check("stray_done_resp_valid", resp_valid, 0);
        check("stray_done_busy", busy, 0);
        $display("stray done in IDLE: resp_valid=%0d busy=%0d", resp_valid, busy);

        // Randomized job mix
        for (int j = 0; j < 6; j++) begin
            int r;
            r = $urandom_range(0, 1);
            if (!pending[r]) submit_rand(r);
            if (!pending[1 - r] && $urandom_range(0, 1) == 1) submit_rand(1 - r);
            job_c = {$urandom, $urandom};
            do_job($urandom_range(0, 40), $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 2 : 0, -1);
        end

        // Reset in the middle of LOAD
        submit(0, {$urandom, $urandom}, 3'b111);
        submit(1, {$urandom, $urandom}, 3'b111);
        job_c = {$urandom, $urandom};
        do_job(0, -1, 0, 4);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_outputs", all_outputs(), 32'd0);
        last_w = 1;
        req_valid = {pending[1], pending[0]};
        drive_req(-1, 0);
        resp_ready = 1'b0;
        mmu_done = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        do_job(0, -1, 0, -1);
        job_c = {$urandom, $urandom};
        do_job(10, -1, 0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mmu_job_scheduler.md
# mmu_job_scheduler

Shares the 2x2 systolic matrix unit between two host-side requesters. Each requester submits a job: 8 operand bytes plus mode flags. The scheduler arbitrates round-robin, then loads the operand memory and starts the array. It captures the four 16-bit results and streams them back as 8 bytes tagged with the requester ID. It sits between the host interface logic and the memory/systolic-array pair, replacing direct host sequencing.

## Interface
- `TIMEOUT`, default 64: cycles allowed in RUN before the job aborts.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 2: per-requester byte valid.
- `req_ready` out 2: per-requester byte accept; at most one bit high.
- `req_data0`, `req_data1` in 8 each: operand bytes, in order w0..w3, i0..i3.
- `req_flags0`, `req_flags1` in 3 each: {elemwise, activation, transpose}; sampled with byte 0.
- `mem_load_en` out 1: operand memory write strobe.
- `mem_addr` out 3: operand memory address.
- `mem_data` out 8: operand memory write data.
- `mmu_clear` out 1: accumulator clear pulse.
- `mmu_start` out 1: compute start pulse.
- `mmu_transpose`, `mmu_activation`, `mmu_elemwise` out 1 each: latched job flags.
- `mmu_done` in 1: array results valid, single-cycle.
- `c00`, `c01`, `c10`, `c11` in 16 each: array results.
- `resp_valid` in→out: out 1; `resp_ready` in 1: response handshake.
- `resp_data` out 8: response byte.
- `resp_id` out 1: requester that owns the response.
- `resp_last` out 1: marks byte 7.
- `resp_err` out 1: job timed out.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - Neither `req_valid` bit set: stay in IDLE.
  - One bit set: grant that requester.
  - Both bits set: grant the requester not granted last.
  - On grant: update the pointer, pulse `mmu_clear` for 1 cycle, go to LOAD. Byte count = 0.
- LOAD: only the granted `req_ready` is high.
  - Each accepted byte (valid & ready) is written to memory at address = byte count, then the count increments.
  - Byte 0 also latches that requester's flags onto `mmu_*`.
  - After byte 7 is accepted, go to RUN.
  - A requester may stall; LOAD has no timeout.
- RUN:
  - `mmu_start` pulses on the first RUN cycle; the wait counter starts at 0.
  - On `mmu_done`: latch `c00`..`c11` into the result buffer, set `resp_err`=0, go to DRAIN.
  - If the counter reaches `TIMEOUT`-1 with no `mmu_done`: load zeros into the buffer, set `resp_err`=1, go to DRAIN.
  - `mmu_done` and timeout expiry in the same cycle: done wins.
  - `mmu_done` outside RUN is ignored.
- DRAIN:
  - `resp_valid`=1. Byte k is sent in order: c00[15:8], c00[7:0], c01 hi, c01 lo, c10 hi, c10 lo, c11 hi, c11 lo.
  - `resp_last`=1 on k=7.
  - Advance on `resp_ready`. When byte 7 is accepted, go to IDLE.
  - `resp_data`, `resp_id` and `resp_err` stay stable while `resp_ready` is low.
- Flags hold their values until the next byte 0.

## Timing
- All outputs are registered.
- Reset value of every output is 0. The round-robin pointer resets so that requester 0 wins the first tie.
- Reset mid-job aborts to IDLE. The partial response is discarded and nothing is written to memory.
- Byte accepted in cycle N: `mem_load_en`/`mem_addr`/`mem_data` are valid in cycle N+1.
- Last byte accepted in cycle N: `mmu_start` is high in cycle N+2.
- `mmu_done` in cycle M: `resp_valid` rises in cycle M+1.
- Minimum job duration with no stalls: 1 (grant) + 8 (load) + 1 (start) + array latency + 8 (drain).
- `req_ready` is never high in RUN or DRAIN. New requests wait in IDLE.

## Structure
- Shared package `tpu_sched_pkg`:
  - state enum;
  - `OPERAND_BYTES`=8, `RESULT_BYTES`=8;
  - flag bit positions;
  - `TIMEOUT` default.
- One sub-module: `rr_arbiter2`, a 2-way round-robin arbiter with a registered last-grant pointer.
- The FSM, counters and the 64-bit result buffer stay in the top module.

## Test plan
- Only requester 0 submits bytes 01..08 with flags 3'b000. Expect:
  - `mem_addr` 0..7 written with 01..08;
  - one `mmu_start` pulse;
  - model returns c00=0x1234 → first response bytes 12,34, `resp_id`=0, `resp_last` on byte 8.
- Both requesters valid from reset. Expect grant order 0,1,0,1 over four jobs, and no `req_ready` to the other requester during a job.
- `resp_ready` held low for 5 cycles at byte 3. Expect `resp_data` unchanged across those cycles and no bytes skipped.
- `mmu_done` withheld. Expect `resp_err`=1 after exactly `TIMEOUT` RUN cycles, 8 zero bytes, then `busy`=0.
- `mmu_done` asserted in the timeout-expiry cycle. Expect `resp_err`=0 and real results returned.
- `rst_n` pulled low during LOAD byte 4. Expect all outputs 0 asynchronously. After release, requester 0 wins a tie and the next job loads from byte 0.
